// File: rtl/pong_collision_engine_if.sv
// Ball/paddle coordinates in, prioritised collision report out.
// Widths follow the engine's XW/YW/CW parameters.
interface pong_collision_engine_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int CW = 8
);
    logic          FrameTick;
    logic [XW-1:0] BallX;
    logic [YW-1:0] BallY;
    logic [YW-1:0] PadLY;
    logic [YW-1:0] PadRY;
    logic          CollValid;
    logic [2:0]    CollCode;
    logic [1:0]    PadZone;
    logic          ScoreL;
    logic          ScoreR;
    logic [CW-1:0] HitCount;

    modport master (
        output FrameTick, BallX, BallY, PadLY, PadRY,
        input  CollValid, CollCode, PadZone, ScoreL, ScoreR, HitCount
    );
    modport slave (
        input  FrameTick, BallX, BallY, PadLY, PadRY,
        output CollValid, CollCode, PadZone, ScoreL, ScoreR, HitCount
    );
endinterface

// File: rtl/pong_collision_engine.sv
// Per-frame ball collision check against walls, ceiling/floor and two paddles.
// Four-state pipeline: latch, raw contact flags, priority resolve, one-cycle report.
module pong_collision_engine #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int CW      = 8,
    parameter int TOP     = 73,
    parameter int BOTTOM  = 392,
    parameter int WALL_L  = 8,
    parameter int WALL_R  = 632,
    parameter int PADL_X  = 32,
    parameter int PADR_X  = 600,
    parameter int PAD_W   = 8,
    parameter int PAD_H   = 100,
    parameter int BALL_SZ = 8
) (
    input logic Clk,
    input logic Rst_n,
    pong_collision_engine_if.slave bus
);
    localparam int XE = XW + 1;
    localparam int YE = YW + 1;
    localparam int OE = YW + 2;
    localparam int ZW = $clog2(PAD_H);

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_PADL  = 3'd1;
    localparam logic [2:0] C_PADR  = 3'd2;
    localparam logic [2:0] C_CEIL  = 3'd3;
    localparam logic [2:0] C_FLOOR = 3'd4;
    localparam logic [2:0] C_WALLL = 3'd5;
    localparam logic [2:0] C_WALLR = 3'd6;

    localparam int F_WALLL = 0, F_WALLR = 1, F_CEIL = 2, F_FLOOR = 3, F_PADL = 4, F_PADR = 5;

    typedef enum logic [1:0] {IDLE, CAPTURE, RESOLVE, REPORT} stateT;
    stateT state, stateNxt;
    logic  latchEn, capEn, resEn;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= IDLE;
        else        state <= stateNxt;

    always_comb begin
        stateNxt = state;
        latchEn  = 1'b0;
        capEn    = 1'b0;
        resEn    = 1'b0;
        case (state)
            IDLE:    if (bus.FrameTick) begin latchEn = 1'b1; stateNxt = CAPTURE; end
            CAPTURE: begin capEn = 1'b1; stateNxt = RESOLVE; end
            RESOLVE: begin resEn = 1'b1; stateNxt = REPORT; end
            default: stateNxt = IDLE;
        endcase
    end

    logic [XW-1:0] bx;
    logic [YW-1:0] by, ply, pry;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            bx <= '0; by <= '0; ply <= '0; pry <= '0;
        end else if (latchEn) begin
            bx <= bus.BallX; by <= bus.BallY; ply <= bus.PadLY; pry <= bus.PadRY;
        end

    // Sums carry one extra bit so edge-of-screen coordinates never wrap.
    logic [XE-1:0] bxE, bxS;
    logic [YE-1:0] byE, byS, plE, prE;
    logic [5:0]    flgNow;
    assign bxE = XE'(bx);
    assign bxS = bxE + XE'(BALL_SZ);
    assign byE = YE'(by);
    assign byS = byE + YE'(BALL_SZ);
    assign plE = YE'(ply);
    assign prE = YE'(pry);

    assign flgNow[F_WALLL] = bxE < XE'(WALL_L);
    assign flgNow[F_WALLR] = bxS > XE'(WALL_R);
    assign flgNow[F_CEIL]  = byE < YE'(TOP);
    assign flgNow[F_FLOOR] = byS > YE'(BOTTOM);
    assign flgNow[F_PADL]  = (bxE < XE'(PADL_X + PAD_W)) && (bxS > XE'(PADL_X)) &&
                             (byE < plE + YE'(PAD_H)) && (byS > plE);
    assign flgNow[F_PADR]  = (bxE < XE'(PADR_X + PAD_W)) && (bxS > XE'(PADR_X)) &&
                             (byE < prE + YE'(PAD_H)) && (byS > prE);

    function automatic logic [ZW-1:0] clampOff(input logic [YW-1:0] y, input logic [YW-1:0] p);
        logic [OE-1:0] d;
        d = OE'(y) + OE'(BALL_SZ / 2) - OE'(p);
        if (d[OE-1])                 return '0;
        else if (d > OE'(PAD_H - 1)) return ZW'(PAD_H - 1);
        else                         return ZW'(d);
    endfunction

    function automatic logic [1:0] zoneOf(input logic [ZW-1:0] off);
        if (off < ZW'(PAD_H / 3))          return 2'd0;
        else if (off < ZW'(2 * PAD_H / 3)) return 2'd1;
        else                               return 2'd2;
    endfunction

    logic [5:0]    flg;
    logic [ZW-1:0] offL, offR;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            flg <= '0; offL <= '0; offR <= '0;
        end else if (capEn) begin
            flg  <= flgNow;
            offL <= clampOff(by, ply);
            offR <= clampOff(by, pry);
        end

    // Later assignments override earlier ones: lowest priority first.
    logic [2:0] win;
    logic [1:0] winZone;
    always_comb begin
        win = C_NONE;
        if (flg[F_PADR])  win = C_PADR;
        if (flg[F_PADL])  win = C_PADL;
        if (flg[F_FLOOR]) win = C_FLOOR;
        if (flg[F_CEIL])  win = C_CEIL;
        if (flg[F_WALLR]) win = C_WALLR;
        if (flg[F_WALLL]) win = C_WALLL;
        winZone = 2'd0;
        if (win == C_PADL)      winZone = zoneOf(offL);
        else if (win == C_PADR) winZone = zoneOf(offR);
    end

    logic          collValid, scoreL, scoreR;
    logic [2:0]    collCode, lock;
    logic [1:0]    padZone;
    logic [CW-1:0] hitCount;

    // A winner equal to the lockout code is swallowed; a clean frame clears the lockout.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            collValid <= 1'b0; scoreL <= 1'b0; scoreR <= 1'b0;
            collCode  <= '0;   padZone <= '0;  hitCount <= '0; lock <= '0;
        end else begin
            collValid <= 1'b0;
            scoreL    <= 1'b0;
            scoreR    <= 1'b0;
            if (resEn) begin
                lock <= win;
                if (win != C_NONE && win != lock) begin
                    collValid <= 1'b1;
                    collCode  <= win;
                    padZone   <= winZone;
                    scoreR    <= (win == C_WALLL);
                    scoreL    <= (win == C_WALLR);
                    if (win == C_PADL || win == C_PADR) begin
                        if (hitCount != '1) hitCount <= hitCount + 1'b1;
                    end else if (win == C_WALLL || win == C_WALLR) begin
                        hitCount <= '0;
                    end
                end
            end
        end

    assign bus.CollValid = collValid;
    assign bus.CollCode  = collCode;
    assign bus.PadZone   = padZone;
    assign bus.ScoreL    = scoreL;
    assign bus.ScoreR    = scoreR;
    assign bus.HitCount  = hitCount;
endmodule

// File: tb/tb_pong_collision_engine.sv
// Randomised frames against a plain-arithmetic collision model, plus literal pins.
// A second instance with CW=2 shares the inputs to exercise HitCount saturation.
module tb_pong_collision_engine;
    localparam int TOP = 73, BOTTOM = 392, WALL_L = 8, WALL_R = 632;
    localparam int PADL_X = 32, PADR_X = 600, PAD_W = 8, PAD_H = 100, BALL = 8;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    pong_collision_engine_if #(.XW(10), .YW(10), .CW(8)) ifc();
    pong_collision_engine_if #(.XW(10), .YW(10), .CW(2)) ifc2();
    assign ifc2.FrameTick = ifc.FrameTick;
    assign ifc2.BallX     = ifc.BallX;
    assign ifc2.BallY     = ifc.BallY;
    assign ifc2.PadLY     = ifc.PadLY;
    assign ifc2.PadRY     = ifc.PadRY;

    pong_collision_engine #(.CW(8)) dut  (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc.slave));
    pong_collision_engine #(.CW(2)) dut2 (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc2.slave));

    int vectors = 0, miscompares = 0, nRep = 0;
    bit chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: winning code from the contact rules and priority order.
    function automatic int winOf(int bx, int by, int pl, int pr);
        bit wl, wr, c, f, pL, pR;
        wl = bx < WALL_L;
        wr = bx + BALL > WALL_R;
        c  = by < TOP;
        f  = by + BALL > BOTTOM;
        pL = bx < PADL_X + PAD_W && bx + BALL > PADL_X && by < pl + PAD_H && by + BALL > pl;
        pR = bx < PADR_X + PAD_W && bx + BALL > PADR_X && by < pr + PAD_H && by + BALL > pr;
        if (wl) return 5;
        if (wr) return 6;
        if (c)  return 3;
        if (f)  return 4;
        if (pL) return 1;
        if (pR) return 2;
        return 0;
    endfunction

    function automatic int zoneOf(int by, int py);
        int off;
        off = by + BALL / 2 - py;
        if (off < 0) off = 0;
        if (off > PAD_H - 1) off = PAD_H - 1;
        return (off < PAD_H / 3) ? 0 : (off < 2 * PAD_H / 3) ? 1 : 2;
    endfunction

    int mw, mz;
    assign mw = winOf(int'(ifc.BallX), int'(ifc.BallY), int'(ifc.PadLY), int'(ifc.PadRY));
    assign mz = (mw == 1) ? zoneOf(int'(ifc.BallY), int'(ifc.PadLY)) :
                (mw == 2) ? zoneOf(int'(ifc.BallY), int'(ifc.PadRY)) : 0;

    int lock, bsy, rd, pv, pcode, pzone;
    int eValid, eCode, eZone, eSL, eSR, eHit, eHit2;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lock <= 0; bsy <= 0; rd <= 0; pv <= 0; pcode <= 0; pzone <= 0;
            eValid <= 0; eCode <= 0; eZone <= 0; eSL <= 0; eSR <= 0; eHit <= 0; eHit2 <= 0;
        end else begin
            eValid <= 0; eSL <= 0; eSR <= 0;
            if (bsy > 0) bsy <= bsy - 1;
            if (rd > 0)  rd <= rd - 1;
            if (rd == 1 && pv != 0) begin
                eValid <= 1; eCode <= pcode; eZone <= pzone;
                eSL <= (pcode == 6); eSR <= (pcode == 5);
                if (pcode == 1 || pcode == 2) begin
                    eHit  <= (eHit < 255) ? eHit + 1 : 255;
                    eHit2 <= (eHit2 < 3) ? eHit2 + 1 : 3;
                end else if (pcode >= 5) begin
                    eHit <= 0; eHit2 <= 0;
                end
            end
            if (bsy == 0 && ifc.FrameTick === 1'b1) begin
                bsy   <= 3;
                rd    <= 2;
                lock  <= mw;
                pv    <= (mw != 0 && mw != lock) ? 1 : 0;
                pcode <= mw;
                pzone <= mz;
            end
        end
    end

    always @(negedge Clk) if (chk) begin
        check("CollValid", ifc.CollValid, eValid);
        check("CollCode",  ifc.CollCode,  eCode);
        check("PadZone",   ifc.PadZone,   eZone);
        check("ScoreL",    ifc.ScoreL,    eSL);
        check("ScoreR",    ifc.ScoreR,    eSR);
        check("HitCount",  ifc.HitCount,  eHit);
        check("HitCount2", ifc2.HitCount, eHit2);
        if (ifc.CollValid === 1'b1) nRep++;
    end

    task automatic drive(input int bx, input int by, input int pl, input int pr);
        ifc.BallX = 10'(bx); ifc.BallY = 10'(by); ifc.PadLY = 10'(pl); ifc.PadRY = 10'(pr);
    endtask

    task automatic scramble();
        drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    // One frame: tick, three busy cycles (outputs captured in the report cycle), back in IDLE.
    task automatic frame(input int bx, input int by, input int pl, input int pr, input bit junk,
                         output int v, output int c, output int z, output int sl, output int sr,
                         output int h, output int h2);
        drive(bx, by, pl, pr);
        ifc.FrameTick = 1'b1;
        @(negedge Clk); ifc.FrameTick = junk ? 1'($urandom) : 1'b0; scramble();
        @(negedge Clk); ifc.FrameTick = junk ? 1'($urandom) : 1'b0;
        @(negedge Clk);
        v = ifc.CollValid; c = ifc.CollCode; z = ifc.PadZone;
        sl = ifc.ScoreL; sr = ifc.ScoreR; h = ifc.HitCount; h2 = ifc2.HitCount;
        ifc.FrameTick = junk ? 1'($urandom) : 1'b0;
        @(negedge Clk); ifc.FrameTick = 1'b0;
    endtask

    function automatic int rx();
        case ($urandom % 5)
            0: return $urandom_range(0, 15);
            1: return $urandom_range(24, 48);
            2: return $urandom_range(590, 640);
            3: return $urandom_range(1010, 1023);
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    function automatic int ry();
        case ($urandom % 5)
            0: return $urandom_range(0, 80);
            1: return $urandom_range(180, 320);
            2: return $urandom_range(380, 400);
            3: return $urandom_range(1015, 1023);
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    initial begin
        int v, c, z, sl, sr, h, h2, r0, bx, by, pl, pr;
        ifc.FrameTick = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge Clk); chk = 1'b1;
        @(negedge Clk); @(negedge Clk);
        check("rst_valid", ifc.CollValid, 0);
        check("rst_code",  ifc.CollCode, 0);
        check("rst_hit",   ifc.HitCount, 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        frame(604, 120, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("padR_valid", v, 1); check("padR_code", c, 2);
        check("padR_zone", z, 0);  check("padR_hit", h, 1);
        frame(604, 120, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("lock_1", v, 0);
        frame(604, 120, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("lock_2", v, 0);
        frame(400, 120, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("clear_frame", v, 0);
        frame(604, 120, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("relock_valid", v, 1); check("relock_hit", h, 2);

        frame(630, 50, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("wallR_code", c, 6); check("wallR_scoreL", sl, 1);
        check("wallR_scoreR", sr, 0); check("wallR_hit", h, 0);

        frame(36, 196, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("zone0_code", c, 1); check("zone0", z, 0);
        frame(300, 200, 200, 100, 0, v, c, z, sl, sr, h, h2);
        frame(36, 240, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("zone1", z, 1);
        frame(300, 200, 200, 100, 0, v, c, z, sl, sr, h, h2);
        frame(36, 290, 200, 100, 0, v, c, z, sl, sr, h, h2);
        check("zone2", z, 2);
        for (int i = 0; i < 2; i++) begin
            frame(300, 200, 200, 100, 0, v, c, z, sl, sr, h, h2);
            frame(36, 240, 200, 100, 0, v, c, z, sl, sr, h, h2);
        end
        check("hit5", h, 5); check("hit_sat_cw2", h2, 3);

        // Second tick one cycle after the first must be ignored.
        frame(300, 200, 200, 100, 0, v, c, z, sl, sr, h, h2);
        r0 = nRep;
        drive(604, 120, 200, 100); ifc.FrameTick = 1'b1;
        @(negedge Clk); drive(36, 240, 200, 100);
        @(negedge Clk); ifc.FrameTick = 1'b0;
        @(negedge Clk); check("busy_code", ifc.CollCode, 2);
        @(negedge Clk); @(negedge Clk);
        check("busy_reports", nRep - r0, 1);

        // Reset two cycles after a tick kills the pending report.
        drive(36, 240, 200, 100); ifc.FrameTick = 1'b1;
        @(negedge Clk); ifc.FrameTick = 1'b0;
        @(negedge Clk); #2 Rst_n = 1'b0;
        @(negedge Clk);
        check("midrst_valid", ifc.CollValid, 0); check("midrst_code", ifc.CollCode, 0);
        check("midrst_hit", ifc.HitCount, 0);
        @(negedge Clk); #2 Rst_n = 1'b1;
        @(negedge Clk);

        bx = 0; by = 0; pl = 0; pr = 0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom % 10 >= 3) begin
                bx = rx(); by = ry();
                pl = ($urandom % 8 == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 400);
                pr = ($urandom % 8 == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 400);
            end
            frame(bx, by, pl, pr, 1, v, c, z, sl, sr, h, h2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
